// File: rtl/fp_exp_pipe.sv
// ---------------------------------------------------------------------------
// fp_exp_pipe
//
// Purpose:
//    Two-stage pipelined exponent datapath shared by the floating-point
//    multiply and divide units. It produces the biased result exponent
//    (a+b-BIAS for MUL, a-b+BIAS for DIV). It flags overflow, underflow and
//    special operands (zero / all-ones exponents), and it keeps sticky
//    overflow/underflow flags. It sits between operand unpack and mantissa
//    normalise/round. Both sides use a valid/ready handshake, and the block
//    sustains one result per cycle.
//
// Parameters:
//    EXP_W   exponent field width (5 = half, 8 = single, 11 = double)
//    BIAS    exponent bias, defaults to 2^(EXP_W-1)-1
//
// Configuration macro:
//    EXP_SAT_EN   when defined, out_exp saturates to all-ones on overflow
//                 and to zero on underflow. When undefined, out_exp is the
//                 low EXP_W bits of the raw result (wrapped). The flags and
//                 raw_exp are the same in both builds.
//
// Ports:
//    clk         in   rising-edge clock
//    rst_n       in   synchronous active-low reset
//    in_valid    in   operand pair valid
//    in_ready    out  operand pair accepted this cycle (combinational)
//    op          in   0 = MUL, 1 = DIV
//    a_exp       in   biased exponent A
//    b_exp       in   biased exponent B
//    out_valid   out  result valid
//    out_ready   in   downstream accepts the result
//    out_exp     out  result exponent (saturated or wrapped)
//    raw_exp     out  signed, unsaturated result exponent (EXP_W+2 bits)
//    out_ovf     out  raw_exp >= 2^EXP_W-1 on a non-special operand pair
//    out_unf     out  raw_exp <= 0 on a non-special operand pair
//    out_spec    out  an operand exponent is zero or all-ones
//    clr_sticky  in   clear both sticky flags
//    sticky_ovf  out  some transferred result carried out_ovf
//    sticky_unf  out  some transferred result carried out_unf
// ---------------------------------------------------------------------------
module fp_exp_pipe #(
   parameter int EXP_W = 5,
   parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op,
   input  logic [EXP_W-1:0]     a_exp,
   input  logic [EXP_W-1:0]     b_exp,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W-1:0]     out_exp,
   output logic [EXP_W+1:0]     raw_exp,
   output logic                 out_ovf,
   output logic                 out_unf,
   output logic                 out_spec,
   input  logic                 clr_sticky,
   output logic                 sticky_ovf,
   output logic                 sticky_unf
);

   // Two guard bits above the exponent field hold both the carry of a+b
   // and the sign of a-b, so no intermediate value ever wraps.
   localparam int W = EXP_W + 2;

   localparam logic signed [W-1:0]  BIAS_S   = W'(BIAS);
   localparam logic signed [W-1:0]  OVF_LIM  = W'((1 << EXP_W) - 1);
   localparam logic signed [W-1:0]  ZERO_S   = '0;
   localparam logic [EXP_W-1:0]     ALL_ONES = '1;
   localparam logic [EXP_W-1:0]     ALL_ZERO = '0;

   // Stage 1 registers
   logic                 v1;
   logic                 op1;
   logic                 spec1;
   logic signed [W-1:0]  s1;

   // Stage enables: a stage may load when it is empty or its contents
   // leave at the same edge. This lets a full pipeline keep streaming
   // without a bubble.
   logic                 en1;
   logic                 en2;

   // Combinational next-state values
   logic signed [W-1:0]  a_ext;
   logic signed [W-1:0]  b_ext;
   logic signed [W-1:0]  s_next;
   logic                 spec_next;
   logic signed [W-1:0]  r_next;
   logic                 ovf_next;
   logic                 unf_next;
   logic [EXP_W-1:0]     exp_next;
   logic                 out_xfer;

   // Handshake. in_ready depends combinationally on out_ready through en2.
   always_comb begin
      en2      = !out_valid || out_ready;
      en1      = !v1 || en2;
      in_ready = en1;
      out_xfer = out_valid && out_ready;
   end

   // Stage 1 arithmetic. The operands are zero-extended before the add or
   // subtract, so a-b comes out as a proper signed difference.
   always_comb begin
      a_ext     = $signed({2'b00, a_exp});
      b_ext     = $signed({2'b00, b_exp});
      s_next    = op ? (a_ext - b_ext) : (a_ext + b_ext);
      spec_next = (a_exp == ALL_ONES) || (b_exp == ALL_ONES) ||
                  (a_exp == ALL_ZERO) || (b_exp == ALL_ZERO);
   end

   // Stage 2 arithmetic and classification. A special operand suppresses
   // both range flags because the exponent is handled elsewhere (inf, NaN,
   // zero, denormal). raw_exp is still produced for such operands.
   always_comb begin
      r_next   = op1 ? (s1 + BIAS_S) : (s1 - BIAS_S);
      ovf_next = !spec1 && (r_next >= OVF_LIM);
      unf_next = !spec1 && (r_next <= ZERO_S);
`ifdef EXP_SAT_EN
      if (ovf_next)
         exp_next = ALL_ONES;
      else if (unf_next)
         exp_next = ALL_ZERO;
      else
         exp_next = r_next[EXP_W-1:0];
`else
      exp_next = r_next[EXP_W-1:0];
`endif
   end

   // Stage 1 register. It holds while stage 2 is stalled and full. Data is
   // loaded only with a valid operand pair, so the register contents stay
   // meaningful.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         op1   <= 1'b0;
         spec1 <= 1'b0;
         s1    <= '0;
      end else if (en1) begin
         v1 <= in_valid;
         if (in_valid) begin
            op1   <= op;
            spec1 <= spec_next;
            s1    <= s_next;
         end
      end
   end

   // Stage 2 register. This register drives the outputs directly, so the
   // result holds stable while out_valid is high and out_ready is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_exp   <= '0;
         raw_exp   <= '0;
         out_ovf   <= 1'b0;
         out_unf   <= 1'b0;
         out_spec  <= 1'b0;
      end else if (en2) begin
         out_valid <= v1;
         if (v1) begin
            out_exp  <= exp_next;
            raw_exp  <= r_next;
            out_ovf  <= ovf_next;
            out_unf  <= unf_next;
            out_spec <= spec1;
         end
      end
   end

   // Sticky flags. They are set only by a result that actually transfers
   // downstream. A set in the same cycle as a clear takes priority, so no
   // event is lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
         sticky_unf <= 1'b0;
      end else begin
         sticky_ovf <= (sticky_ovf && !clr_sticky) || (out_xfer && out_ovf);
         sticky_unf <= (sticky_unf && !clr_sticky) || (out_xfer && out_unf);
      end
   end

endmodule

// File: tb/tb_fp_exp_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_exp_pipe
//
// Purpose:
//    Self-checking bench for fp_exp_pipe with EXP_W=5 and BIAS=15. It runs
//    the directed scenarios first and then a randomized handshake stream.
//    A queue-based reference model computes the expected exponent and
//    flags, the cycle in which each result becomes visible, in_ready, and
//    the sticky flags.
//    If the design is built with EXP_SAT_EN, the bench must be built with
//    the same macro.
// ---------------------------------------------------------------------------
module tb_fp_exp_pipe;

   localparam int EXP_W = 5;
   localparam int BIAS  = 15;
   localparam int ALL1  = (1 << EXP_W) - 1;
   localparam int RAWM  = (1 << (EXP_W + 2)) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             op = 1'b0;
   logic [EXP_W-1:0] a_exp = '0;
   logic [EXP_W-1:0] b_exp = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [EXP_W-1:0] out_exp;
   logic [EXP_W+1:0] raw_exp;
   logic             out_ovf;
   logic             out_unf;
   logic             out_spec;
   logic             clr_sticky = 1'b0;
   logic             sticky_ovf;
   logic             sticky_unf;

   fp_exp_pipe #(.EXP_W(EXP_W), .BIAS(BIAS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a_exp(a_exp), .b_exp(b_exp), .out_valid(out_valid),
      .out_ready(out_ready), .out_exp(out_exp), .raw_exp(raw_exp),
      .out_ovf(out_ovf), .out_unf(out_unf), .out_spec(out_spec),
      .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      int raw;
      bit ovf;
      bit unf;
      bit spec;
      int oexp;
      int acc;
   } exp_t;

   exp_t pipe_q[$];
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;
   bit   m_sovf = 1'b0;
   bit   m_sunf = 1'b0;
   int   last_exp, last_raw, last_lat;
   int   last_ovf, last_unf, last_spec;

   // Reference model: the plain integer exponent arithmetic with range
   // classification
   function automatic exp_t refModel(input bit o, input int a, input int b);
      exp_t e;
      int   r;
      e.spec = (a == ALL1) || (b == ALL1) || (a == 0) || (b == 0);
      r      = o ? (a - b + BIAS) : (a + b - BIAS);
      e.raw  = r & RAWM;
      e.ovf  = !e.spec && (r >= ALL1);
      e.unf  = !e.spec && (r <= 0);
`ifdef EXP_SAT_EN
      e.oexp = e.ovf ? ALL1 : (e.unf ? 0 : (r & ALL1));
`else
      e.oexp = r & ALL1;
`endif
      e.acc  = 0;
      return e;
   endfunction

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input int got, input int want);
      total++;
      if (got == want)
         passed++;
      else
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
   endtask

   // Drive one cycle of inputs, check every output against the model at
   // the falling edge, and then advance the model across the rising edge
   task automatic applyStimulus(input bit iv, input bit o, input int a, input int b,
                                input bit ordy, input bit clr, output bit acc);
      bit exp_vld, exp_rdy, xfer, set_ovf, set_unf;
      exp_t e;
      in_valid   = iv;
      op         = o;
      a_exp      = a[EXP_W-1:0];
      b_exp      = b[EXP_W-1:0];
      out_ready  = ordy;
      clr_sticky = clr;
      @(negedge clk);
      exp_vld = (pipe_q.size() > 0) && (cyc >= pipe_q[0].acc + 2);
      exp_rdy = (pipe_q.size() < 2) || ordy;
      checkOutput("out_valid", out_valid, exp_vld);
      checkOutput("in_ready", in_ready, exp_rdy);
      checkOutput("sticky_ovf", sticky_ovf, m_sovf);
      checkOutput("sticky_unf", sticky_unf, m_sunf);
      xfer    = exp_vld && ordy;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (exp_vld && out_valid) begin
         checkOutput("out_exp", out_exp, pipe_q[0].oexp);
         checkOutput("raw_exp", raw_exp, pipe_q[0].raw);
         checkOutput("out_ovf", out_ovf, pipe_q[0].ovf);
         checkOutput("out_unf", out_unf, pipe_q[0].unf);
         checkOutput("out_spec", out_spec, pipe_q[0].spec);
      end
      if (xfer) begin
         last_exp  = out_exp;
         last_raw  = raw_exp;
         last_ovf  = out_ovf;
         last_unf  = out_unf;
         last_spec = out_spec;
         last_lat  = cyc - pipe_q[0].acc;
         set_ovf   = pipe_q[0].ovf;
         set_unf   = pipe_q[0].unf;
         void'(pipe_q.pop_front());
      end
      m_sovf = (m_sovf && !clr) || set_ovf;
      m_sunf = (m_sunf && !clr) || set_unf;
      acc = iv && exp_rdy;
      if (acc) begin
         e     = refModel(o, a, b);
         e.acc = cyc;
         pipe_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Hold reset low for one edge. The model drops all in-flight results.
   task automatic doReset();
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      clr_sticky = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pipe_q.delete();
      m_sovf = 1'b0;
      m_sunf = 1'b0;
      cyc++;
   endtask

   task automatic idle(input bit ordy, input bit clr);
      bit acc;
      applyStimulus(1'b0, 1'b0, 0, 0, ordy, clr, acc);
   endtask

   initial begin : main
      bit acc;
      int nacc;
      int pa[4] = '{10, 20, 7, 16};
      int pb[4] = '{12, 3, 9, 16};
      int idx;

      $display("[TB] start");
      doReset();
      idle(1'b1, 1'b0);
      checkOutput("rst_out_exp", out_exp, 0);
      checkOutput("rst_out_ovf", out_ovf, 0);

      // MUL 15*15: nominal exponent, two-cycle latency
      applyStimulus(1'b1, 1'b0, 15, 15, 1'b1, 1'b0, acc);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t1_exp", last_exp, 15);
      checkOutput("t1_lat", last_lat, 2);
      checkOutput("t1_flags", {last_ovf[0], last_unf[0], last_spec[0]}, 0);

      // MUL 30*30: overflow
      applyStimulus(1'b1, 1'b0, 30, 30, 1'b1, 1'b0, acc);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t2_raw", last_raw, 45);
      checkOutput("t2_ovf", last_ovf, 1);
`ifdef EXP_SAT_EN
      checkOutput("t2_exp", last_exp, 31);
`else
      checkOutput("t2_exp", last_exp, 13);
`endif
      checkOutput("t2_sticky", sticky_ovf, 1);

      // DIV 1/20: underflow, negative raw exponent
      applyStimulus(1'b1, 1'b1, 1, 20, 1'b1, 1'b0, acc);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t3_raw", last_raw, 124);
      checkOutput("t3_unf", last_unf, 1);
`ifdef EXP_SAT_EN
      checkOutput("t3_exp", last_exp, 0);
`else
      checkOutput("t3_exp", last_exp, 28);
`endif
      checkOutput("t3_sticky", sticky_unf, 1);

      // Stream four pairs into a stalled pipeline, then release the stall
      nacc = 0;
      idx  = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, pa[idx], pb[idx], 1'b0, 1'b0, acc);
         if (acc) begin
            nacc++;
            idx++;
         end
      end
      checkOutput("t4_accepted", nacc, 2);
      checkOutput("t4_in_ready", in_ready, 0);
      for (int i = 0; i < 12; i++) begin
         if (idx < 4) begin
            applyStimulus(1'b1, 1'b0, pa[idx], pb[idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
         end else begin
            idle(1'b1, 1'b0);
         end
      end
      checkOutput("t4_sent", idx, 4);
      checkOutput("t4_drained", pipe_q.size(), 0);

      // Special operands leave the stickies alone
      idle(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 31, 3, 1'b1, 1'b0, acc);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t5_spec_a", last_spec, 1);
      applyStimulus(1'b1, 1'b0, 0, 9, 1'b1, 1'b0, acc);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      checkOutput("t5_spec_b", last_spec, 1);
      checkOutput("t5_unf_masked", last_unf, 0);
      checkOutput("t5_stickies", {sticky_ovf, sticky_unf}, 0);

      // A clear in the same cycle as an overflow transfer keeps sticky_ovf set
      applyStimulus(1'b1, 1'b1, 1, 20, 1'b1, 1'b0, acc);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 30, 30, 1'b0, 1'b0, acc);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b1, 1'b1);
      checkOutput("t5_clr_set_ovf", sticky_ovf, 1);
      checkOutput("t5_clr_unf", sticky_unf, 0);

      // Reset with both stages full and the stickies set
      applyStimulus(1'b1, 1'b0, 30, 30, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 1'b0, 29, 29, 1'b0, 1'b0, acc);
      checkOutput("t6_full", pipe_q.size(), 2);
      doReset();
      checkOutput("t6_valid", out_valid, 0);
      checkOutput("t6_sticky", {sticky_ovf, sticky_unf}, 0);
      checkOutput("t6_in_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);

      // Randomized stream with random backpressure, clears and resets
      for (int i = 0; i < 600; i++) begin
         int a, b;
         a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? ALL1 : 0)
                                         : $urandom_range(0, ALL1);
         b = $urandom_range(0, ALL1);
         if ($urandom_range(0, 199) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, b,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, acc);
         end
      end
      for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
      checkOutput("final_drained", pipe_q.size(), 0);

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
